// File: rtl/mc_control_pkg.sv
// mc_control_pkg: shared definitions for the multicycle CPU control FSM.
//   - state codes (FETCH..JUMP, plus ADDI_EX/ADDI_WB when MC_CONTROL_ADDI_EN
//     is defined)
//   - opcode constants for the decoded instruction classes
//   - pc_source / alu_src_b / alu_op encodings, shared with the datapath muxes
//   - ctrl_t: bundle of every datapath control signal
// Optional feature macro: MC_CONTROL_ADDI_EN (adds the addi states).
package mc_control_pkg;

   localparam int OPC_W_DEF   = 6;
   localparam int STATE_W_DEF = 4;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADDR  = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_RTYPE_WB = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9
`ifdef MC_CONTROL_ADDI_EN
      ,
      S_ADDI_EX  = 4'd10,
      S_ADDI_WB  = 4'd11
`endif
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   // pc_source drives the S input of the 3-input PC mux; 2'b11 is never used.
   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_SEXT    = 2'b10;
   localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       reg_dst;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

endpackage

// File: rtl/mc_control_decode.sv
// mc_control_decode: combinational state -> control-signal table.
// Ports:
//   state_i   in  current FSM state
//   reset_n   in  active-low reset; while low every control output is 0
//   mem_ready in  memory handshake; qualifies the FETCH-cycle IR/PC loads
//   ctrl_o    out all datapath enables and selects
// Optional feature macro: MC_CONTROL_ADDI_EN (decodes ADDI_EX/ADDI_WB).
module mc_control_decode
   import mc_control_pkg::*;
(
   input  state_e state_i,
   input  logic   reset_n,
   input  logic   mem_ready,
   output ctrl_t  ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      if (reset_n) begin
         unique case (state_i)
            S_FETCH: begin
               ctrl_o.mem_read  = 1'b1;
               ctrl_o.alu_src_b = SRCB_FOUR;
               ctrl_o.alu_op    = ALUOP_ADD;
               ctrl_o.pc_source = PC_SRC_ALU;
               // IR and PC load only in the cycle the fetch completes.
               ctrl_o.ir_write  = mem_ready;
               ctrl_o.pc_write  = mem_ready;
            end
            S_DECODE: begin
               ctrl_o.alu_src_b = SRCB_SEXT_SH;
               ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMADDR: begin
               ctrl_o.alu_src_a = 1'b1;
               ctrl_o.alu_src_b = SRCB_SEXT;
            end
            S_MEMREAD: begin
               ctrl_o.mem_read = 1'b1;
               ctrl_o.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
               ctrl_o.reg_write  = 1'b1;
               ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
               ctrl_o.mem_write = 1'b1;
               ctrl_o.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
               ctrl_o.alu_src_a = 1'b1;
               ctrl_o.alu_src_b = SRCB_B;
               ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_RTYPE_WB: begin
               ctrl_o.reg_write = 1'b1;
               ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
               ctrl_o.alu_src_a     = 1'b1;
               ctrl_o.alu_src_b     = SRCB_B;
               ctrl_o.alu_op        = ALUOP_SUB;
               ctrl_o.pc_write_cond = 1'b1;
               ctrl_o.pc_source     = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
               ctrl_o.pc_write  = 1'b1;
               ctrl_o.pc_source = PC_SRC_JUMP;
            end
`ifdef MC_CONTROL_ADDI_EN
            S_ADDI_EX: begin
               ctrl_o.alu_src_a = 1'b1;
               ctrl_o.alu_src_b = SRCB_SEXT;
               ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_ADDI_WB: begin
               ctrl_o.reg_write = 1'b1;
            end
`endif
            // Illegal codes leave every output at 0.
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/mc_control.sv
// mc_control: Moore-style control FSM for the multicycle CPU datapath.
// Sequences fetch/decode/execute/memory/writeback for R-type, lw, sw, beq, j.
// Ports:
//   clk, reset_n        clock (rising edge) and synchronous active-low reset
//   opcode              IR[31:26], valid from DECODE onward
//   zero                ALU zero flag (consumed in the datapath, not here)
//   mem_ready           memory handshake, see below
//   pc_write .. pc_source  datapath enables and selects
//   state               current state code, exported for debug
// Handshake: mem_read / mem_write are requests held high for as long as the
// FSM sits in a memory state; mem_ready=1 in a cycle means the memory
// completes that access in that same cycle, and the FSM advances at the next
// edge. With mem_ready=0 the FSM holds and the request stays asserted.
// Optional feature macro: MC_CONTROL_ADDI_EN (adds addi via ADDI_EX/ADDI_WB).
module mc_control
   import mc_control_pkg::*;
#(
   parameter int OPC_W   = OPC_W_DEF,
   parameter int STATE_W = STATE_W_DEF
)(
   input  logic               clk,
   input  logic               reset_n,
   input  logic [OPC_W-1:0]   opcode,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               i_or_d,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               mem_to_reg,
   output logic               reg_write,
   output logic               reg_dst,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic [1:0]         pc_source,
   output logic [STATE_W-1:0] state
);

   state_e state_q, state_d;
   ctrl_t  ctrl;
   logic   unused_zero;

   // The branch condition is resolved in the datapath (pc_write_cond & zero).
   assign unused_zero = zero;

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= S_FETCH;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      unique case (state_q)
         S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if      (opcode == OP_RTYPE)                     state_d = S_EXECUTE;
            else if (opcode == OP_LW || opcode == OP_SW)     state_d = S_MEMADDR;
            else if (opcode == OP_BEQ)                       state_d = S_BRANCH;
            else if (opcode == OP_J)                         state_d = S_JUMP;
`ifdef MC_CONTROL_ADDI_EN
            else if (opcode == OP_ADDI)                      state_d = S_ADDI_EX;
`endif
            else                                             state_d = S_FETCH;
         end
         S_MEMADDR:  state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECUTE:  state_d = S_RTYPE_WB;
         S_RTYPE_WB: state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_JUMP:     state_d = S_FETCH;
`ifdef MC_CONTROL_ADDI_EN
         S_ADDI_EX:  state_d = S_ADDI_WB;
         S_ADDI_WB:  state_d = S_FETCH;
`endif
         default:    state_d = S_FETCH;
      endcase
   end

   mc_control_decode u_decode (
      .state_i   (state_q),
      .reset_n   (reset_n),
      .mem_ready (mem_ready),
      .ctrl_o    (ctrl)
   );

   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign i_or_d        = ctrl.i_or_d;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign ir_write      = ctrl.ir_write;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign reg_write     = ctrl.reg_write;
   assign reg_dst       = ctrl.reg_dst;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign alu_op        = ctrl.alu_op;
   assign pc_source     = ctrl.pc_source;
   assign state         = STATE_W'(state_q);

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Moore-style control FSM for the multicycle CPU datapath.
- Sequences fetch/decode/execute/memory/writeback for R-type, lw, sw, beq and j.
- Drives every datapath enable and select, including the 2-bit `pc_source` that is the S input of the 3-input PC-source mux directly downstream.
- Stalls on a memory-ready handshake.

Parameters:
- `OPC_W`, 6, opcode field width.
- `STATE_W`, 4, state register width (exported for debug).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  synchronous reset, active-low.
- `opcode`  in  `OPC_W`  IR[31:26], valid from DECODE onward.
- `zero`  in  1  ALU zero flag. Not used by this block; `pc_write_cond` is ANDed with `zero` in the datapath.
- `mem_ready`  in  1  memory completes current access this cycle.
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load if branch taken.
- `i_or_d`  out  1  0=PC address, 1=ALUOut address.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `ir_write`  out  1  instruction register load.
- `mem_to_reg`  out  1  0=ALUOut, 1=MDR to register file.
- `reg_write`  out  1  register file write.
- `reg_dst`  out  1  0=rt, 1=rd.
- `alu_src_a`  out  1  0=PC, 1=A.
- `alu_src_b`  out  2  00=B, 01=4, 10=signext, 11=signext<<2.
- `alu_op`  out  2  00=add, 01=sub, 10=funct.
- `pc_source`  out  2  00=ALU result, 01=ALUOut, 10=jump target; 11 never driven.
- `state`  out  `STATE_W`  current state code.

Behaviour:
- States and codes:
  - FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, RTYPE_WB=7, BRANCH=8, JUMP=9.
  - Codes 10–15 are illegal and return to FETCH next cycle with all outputs 0.
- Reset:
  - While `reset_n`=0 at a rising edge, `state`←FETCH.
  - While `reset_n`=0, all control outputs are forced 0 combinationally; `state` output reads 0 after the edge.
  - `reset_n` low mid-instruction aborts it; no write strobe is asserted during the reset cycle.
- Outputs are a pure function of `state` (gated by `reset_n`). Only the signals listed per state are nonzero.
  - FETCH: `mem_read`, `alu_src_b`=01, `alu_op`=00, `pc_source`=00. When `mem_ready`=1, also `ir_write`, `pc_write`. Go to DECODE if `mem_ready`=1, else hold.
  - DECODE: `alu_src_b`=11, `alu_op`=00. Next state by opcode:
    - 000000→EXECUTE
    - 100011 or 101011→MEMADDR
    - 000100→BRANCH
    - 000010→JUMP
    - any other→FETCH (treated as NOP)
  - MEMADDR: `alu_src_a`=1, `alu_src_b`=10. Next: MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: `mem_read`, `i_or_d`=1. Go to MEMWB on `mem_ready`=1, else hold.
  - MEMWB: `reg_write`, `mem_to_reg`=1, `reg_dst`=0. Next: FETCH.
  - MEMWRITE: `mem_write`, `i_or_d`=1. Go to FETCH on `mem_ready`=1, else hold; `mem_write` stays high while holding.
  - EXECUTE: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next: RTYPE_WB.
  - RTYPE_WB: `reg_write`, `reg_dst`=1, `mem_to_reg`=0. Next: FETCH.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`, `pc_source`=01. Next: FETCH.
  - JUMP: `pc_write`, `pc_source`=10. Next: FETCH.
- Latency with `mem_ready` held 1: lw 5, sw 4, R-type 4, beq 3, j 3 cycles. Each wait cycle adds 1.
- `mem_read` and `mem_write` are never high in the same cycle.
- `pc_write` and `pc_write_cond` are never high in the same cycle.

Optional Feature:
- Macro: `MC_CONTROL_ADDI_EN`.
- Defined:
  - Adds ADDI_EX=10 and ADDI_WB=11, so codes 12–15 become the illegal set.
  - In DECODE, opcode 001000→ADDI_EX.
  - ADDI_EX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - ADDI_WB: `reg_write`, `reg_dst`=0, `mem_to_reg`=0, then FETCH.
  - addi latency is 4 cycles.
- Undefined: opcode 001000 decodes as NOP (DECODE→FETCH), and codes 10–15 stay illegal.

Decomposition:
- Package `mc_control_pkg` holds:
  - state code constants;
  - opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_J`, `OP_ADDI`);
  - `pc_source`, `alu_src_b` and `alu_op` encodings, shared with the datapath muxes.
- Sub-module `mc_control_decode`: combinational state→outputs table.
- Top module: state register plus next-state logic.

Test Plan:
- Reset: `reset_n`=0 for 2 cycles in any state → `state`=0, all outputs 0. Release with `mem_ready`=1 → FETCH outputs `mem_read`=1, `ir_write`=1, `pc_write`=1, `pc_source`=00.
- lw (`opcode`=100011), `mem_ready`=1 → `state` sequence 0,1,2,3,4,0. `reg_write`=1 and `mem_to_reg`=1 only in cycle 5.
- sw (101011) with `mem_ready`=0 for 3 cycles in MEMWRITE → `state`=5 held 4 cycles, `mem_write`=1 throughout, then `state`=0.
- beq (000100), then j (000010) → beq sequence 0,1,8 with `pc_write_cond`=1 and `pc_source`=01 in state 8; j sequence 0,1,9 with `pc_write`=1 and `pc_source`=10; `pc_source` never 11.
- R-type (000000), then unknown opcode 111111 → R-type sequence 0,1,6,7 with `reg_dst`=1 in state 7; unknown opcode goes 0,1,0 with no write strobes.
- With `MC_CONTROL_ADDI_EN` defined, opcode 001000 → 0,1,10,11,0 with `alu_src_b`=10 in state 10. Without it → 0,1,0.
